// File: rtl/renode_axi_subordinate_ram.sv
// AXI4 subordinate backed by a word-addressed RAM; one write burst and one read burst in flight.
// Latency: AW->W ready next cycle, last W->B next cycle, AR->first R beat next cycle.
// Backpressure: B and R payloads are held while valid and not ready; AW/AR are refused until the burst retires.
// Build option: RENODE_AXI_SUBORDINATE_WRAP_EN enables WRAP bursts (otherwise every WRAP burst is SLVERR).
// Ports: clk/areset (sync, active-high); AXI4 AW/W/B/AR/R channels; lock/cache/prot are accepted and ignored.
module renode_axi_subordinate_ram #(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8,
  parameter int MemoryDepth        = 1024
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic [TransactionIdWidth-1:0] awid,
  input  logic [AddressWidth-1:0]       awaddr,
  input  logic [7:0]                    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          awlock,
  input  logic [3:0]                    awcache,
  input  logic [2:0]                    awprot,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [DataWidth-1:0]          wdata,
  input  logic [DataWidth/8-1:0]        wstrb,
  input  logic                          wlast,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [TransactionIdWidth-1:0] bid,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [TransactionIdWidth-1:0] arid,
  input  logic [AddressWidth-1:0]       araddr,
  input  logic [7:0]                    arlen,
  input  logic [2:0]                    arsize,
  input  logic [1:0]                    arburst,
  input  logic                          arlock,
  input  logic [3:0]                    arcache,
  input  logic [2:0]                    arprot,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [TransactionIdWidth-1:0] rid,
  output logic [DataWidth-1:0]          rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready
);

  localparam int StrobeWidth = DataWidth / 8;
  localparam int Log2Strb    = $clog2(StrobeWidth);
  localparam int IdxW        = $clog2(MemoryDepth);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  logic [DataWidth-1:0] mem_q [MemoryDepth];

  logic unused_sideband;
  assign unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arprot};

  // Response encodings are ordered by severity, so numeric max picks the worst.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic basic_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'(Log2Strb)) || (burst == 2'b11);
  endfunction

  // A zero mask means non-wrapping; a non-zero mask keeps the upper bits at the wrap base.
  function automatic logic [AddressWidth-1:0] next_addr(input logic [AddressWidth-1:0] addr,
      input logic [2:0] size, input logic [1:0] burst, input logic [AddressWidth-1:0] mask);
    logic [AddressWidth-1:0] inc;
    inc = addr + (AddressWidth'(1) << size);
    if (burst == BURST_FIXED) return addr;
    if (mask == '0) return inc;
    return (addr & ~mask) | (inc & mask);
  endfunction

  logic                    aw_err, ar_err;
  logic [AddressWidth-1:0] aw_mask, ar_mask;

`ifdef RENODE_AXI_SUBORDINATE_WRAP_EN
  function automatic logic wrap_bad(input logic [AddressWidth-1:0] addr, input logic [7:0] len,
      input logic [2:0] size);
    logic len_ok;
    len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return !len_ok || ((addr & ((AddressWidth'(1) << size) - 1'b1)) != '0);
  endfunction

  function automatic logic [AddressWidth-1:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
    return ((AddressWidth'(len) + 1'b1) << size) - 1'b1;
  endfunction

  assign aw_err  = basic_bad(awsize, awburst) || ((awburst == BURST_WRAP) && wrap_bad(awaddr, awlen, awsize));
  assign ar_err  = basic_bad(arsize, arburst) || ((arburst == BURST_WRAP) && wrap_bad(araddr, arlen, arsize));
  assign aw_mask = (awburst == BURST_WRAP) ? wrap_mask(awlen, awsize) : '0;
  assign ar_mask = (arburst == BURST_WRAP) ? wrap_mask(arlen, arsize) : '0;
`else
  assign aw_err  = basic_bad(awsize, awburst) || (awburst == BURST_WRAP);
  assign ar_err  = basic_bad(arsize, arburst) || (arburst == BURST_WRAP);
  assign aw_mask = '0;
  assign ar_mask = '0;
`endif

  // ---------------- write engine ----------------
  w_state_e                      w_state_q;
  logic                          awready_q, wready_q, bvalid_q;
  logic [TransactionIdWidth-1:0] bid_q;
  logic [1:0]                    bresp_q, w_acc_q;
  logic [AddressWidth-1:0]       w_addr_q, w_mask_q;
  logic [7:0]                    w_len_q, w_cnt_q;
  logic [2:0]                    w_size_q;
  logic [1:0]                    w_burst_q;
  logic                          w_err_q;

  logic       w_hs, w_last_beat, w_oor, mem_we;
  logic [1:0] w_beat_resp;
  logic [IdxW-1:0] w_idx;

  always_comb begin
    w_hs        = wvalid && wready_q;
    w_last_beat = (w_cnt_q == w_len_q);
    w_oor       = (w_addr_q >> Log2Strb) >= AddressWidth'(MemoryDepth);
    w_idx       = w_addr_q[Log2Strb +: IdxW];
    w_beat_resp = RESP_OKAY;
    if (w_err_q)    w_beat_resp = RESP_SLVERR;
    else if (w_oor) w_beat_resp = RESP_DECERR;
    // Beat counter decides burst length; a misplaced wlast only taints the response.
    if (wlast != w_last_beat) w_beat_resp = resp_max(w_beat_resp, RESP_SLVERR);
    mem_we = w_hs && !w_err_q && !w_oor && !areset;
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      w_acc_q   <= RESP_OKAY;
      w_addr_q  <= '0;
      w_mask_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= awid;
            w_addr_q  <= awaddr;
            w_mask_q  <= aw_mask;
            w_len_q   <= awlen;
            w_size_q  <= awsize;
            w_burst_q <= awburst;
            w_err_q   <= aw_err;
            w_cnt_q   <= '0;
            w_acc_q   <= RESP_OKAY;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_acc_q <= resp_max(w_acc_q, w_beat_resp);
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= resp_max(w_acc_q, w_beat_resp);
              w_state_q <= W_RESP;
            end else begin
              w_cnt_q  <= w_cnt_q + 8'd1;
              w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q, w_mask_q);
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < StrobeWidth; b++) begin
        if (wstrb[b]) mem_q[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;

  // ---------------- read engine ----------------
  r_state_e                      r_state_q;
  logic                          arready_q, rvalid_q;
  logic [TransactionIdWidth-1:0] rid_q;
  logic [AddressWidth-1:0]       r_addr_q, r_mask_q;
  logic [7:0]                    r_len_q, r_cnt_q;
  logic [2:0]                    r_size_q;
  logic [1:0]                    r_burst_q;
  logic                          r_err_q;

  logic       r_last_beat, r_oor;
  logic [1:0] r_beat_resp;
  logic [IdxW-1:0] r_idx;

  always_comb begin
    r_last_beat = (r_cnt_q == r_len_q);
    r_oor       = (r_addr_q >> Log2Strb) >= AddressWidth'(MemoryDepth);
    r_idx       = r_addr_q[Log2Strb +: IdxW];
    r_beat_resp = RESP_OKAY;
    if (r_err_q)    r_beat_resp = RESP_SLVERR;
    else if (r_oor) r_beat_resp = RESP_DECERR;
  end

  // Read data is taken straight from the array, so a same-cycle write is not yet visible.
  assign rdata = (rvalid_q && r_beat_resp == RESP_OKAY) ? mem_q[r_idx] : '0;
  assign rresp = rvalid_q ? r_beat_resp : RESP_OKAY;
  assign rlast = rvalid_q && r_last_beat;

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      r_addr_q  <= '0;
      r_mask_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= arid;
            r_addr_q  <= araddr;
            r_mask_q  <= ar_mask;
            r_len_q   <= arlen;
            r_size_q  <= arsize;
            r_burst_q <= arburst;
            r_err_q   <= ar_err;
            r_cnt_q   <= '0;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_last_beat) begin
              rvalid_q  <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_cnt_q  <= r_cnt_q + 8'd1;
              r_addr_q <= next_addr(r_addr_q, r_size_q, r_burst_q, r_mask_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;

endmodule

// File: tb/tb_renode_axi_subordinate_ram.sv
// Directed bench for renode_axi_subordinate_ram: write/read bursts, error responses, WRAP, stalls, mid-burst reset.
// Latency: one AXI transaction at a time, handshake timing checked against fixed cycle offsets.
// Backpressure: bready/rready are withheld for several cycles to check payload hold.
module tb_renode_axi_subordinate_ram;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache, wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  renode_axi_subordinate_ram dut (
    .clk(clk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-burst stimulus and captured results.
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wflip [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [1:0]  b_resp_got;
  logic [7:0]  b_id_got, r_id_got;

  function automatic logic sig(input int s);
    case (s)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      4: return rvalid;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait; sampling happens 1 time unit after the rising edge.
  task automatic wait_hi(input int s, input string tag);
    int n = 0;
    while (!sig(s) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({"hs_", tag}, 64'(sig(s)), 64'd1);
  endtask

  task automatic axi_wr(input logic [31:0] addr, input int len, input logic [2:0] size,
                        input logic [1:0] burst, input logic [7:0] id, input int bstall);
    awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    wait_hi(0, "aw");
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("wready_lat", 64'(wready), 64'd1);
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == len) ^ wflip[i];
      wait_hi(1, "w");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_lat", 64'(bvalid), 64'd1);
    for (int i = 0; i < bstall; i++) begin
      @(posedge clk); #1;
      chk("b_hold_vld", 64'(bvalid), 64'd1);
      chk("b_hold_id", 64'(bid), 64'(id));
    end
    bready = 1'b1;
    wait_hi(2, "b");
    b_resp_got = bresp; b_id_got = bid;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("awready_lat", 64'(awready), 64'd1);
    for (int i = 0; i < 16; i++) begin ws[i] = 4'hF; wflip[i] = 1'b0; end
  endtask

  task automatic axi_rd(input logic [31:0] addr, input int len, input logic [2:0] size,
                        input logic [1:0] burst, input logic [7:0] id, input int rstall,
                        input logic [31:0] exp0);
    araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    wait_hi(3, "ar");
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid_lat", 64'(rvalid), 64'd1);
    for (int i = 0; i < rstall; i++) begin
      @(posedge clk); #1;
      chk("r_hold_vld", 64'(rvalid), 64'd1);
      chk("r_hold_data", 64'(rdata), 64'(exp0));
      chk("r_hold_id", 64'(rid), 64'(id));
    end
    rready = 1'b1;
    for (int i = 0; i <= len; i++) begin
      wait_hi(4, "r");
      rd[i] = rdata; rr[i] = rresp; rl[i] = rlast; r_id_got = rid;
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0;
    awcache = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    wvalid = 1'b0; bready = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0;
    arburst = '0; arlock = 1'b0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 16; i++) begin ws[i] = 4'hF; wflip[i] = 1'b0; wd[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_outs", 64'({bid, bresp, rid, rresp, rdata}), 64'd0);
    areset = 1'b0;
    @(posedge clk); #1;
    chk("idle_awready", 64'(awready), 64'd1);
    chk("idle_arready", 64'(arready), 64'd1);

    // Single beat write then read back.
    wd[0] = 32'hDEADBEEF;
    axi_wr(32'h10, 0, 3'd2, 2'b01, 8'h5A, 0);
    chk("t1_bresp", 64'(b_resp_got), 64'd0);
    chk("t1_bid", 64'(b_id_got), 64'h5A);
    axi_rd(32'h10, 0, 3'd2, 2'b01, 8'h3C, 0, 32'h0);
    chk("t1_rdata", 64'(rd[0]), 64'hDEADBEEF);
    chk("t1_rresp", 64'(rr[0]), 64'd0);
    chk("t1_rlast", 64'(rl[0]), 64'd1);
    chk("t1_rid", 64'(r_id_got), 64'h3C);

    // INCR burst with a partial strobe on beat 2.
    for (int i = 0; i < 4; i++) wd[i] = 32'hFFFFFFFF;
    axi_wr(32'h0, 3, 3'd2, 2'b01, 8'h01, 0);
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33334444; wd[3] = 32'h44444444;
    ws[2] = 4'b0011;
    axi_wr(32'h0, 3, 3'd2, 2'b01, 8'h02, 0);
    chk("t2_bresp", 64'(b_resp_got), 64'd0);
    axi_rd(32'h0, 3, 3'd2, 2'b01, 8'h03, 0, 32'h0);
    chk("t2_beat0", 64'(rd[0]), 64'h11111111);
    chk("t2_beat1", 64'(rd[1]), 64'h22222222);
    chk("t2_beat2", 64'(rd[2]), 64'hFFFF4444);
    chk("t2_beat3", 64'(rd[3]), 64'h44444444);
    chk("t2_rlast0", 64'(rl[0]), 64'd0);
    chk("t2_rlast3", 64'(rl[3]), 64'd1);

    // Out of range word index.
    wd[0] = 32'hCAFEF00D;
    axi_wr(32'h1000, 0, 3'd2, 2'b01, 8'h04, 0);
    chk("t3_bresp", 64'(b_resp_got), 64'd3);
    axi_rd(32'h1000, 0, 3'd2, 2'b01, 8'h05, 0, 32'h0);
    chk("t3_rresp", 64'(rr[0]), 64'd3);
    chk("t3_rdata", 64'(rd[0]), 64'd0);

    // Oversized beat: SLVERR and memory untouched.
    wd[0] = 32'h12345678;
    axi_wr(32'h40, 0, 3'd2, 2'b01, 8'h06, 0);
    wd[0] = 32'h0;
    axi_wr(32'h40, 0, 3'd3, 2'b01, 8'h07, 0);
    chk("t5_bresp", 64'(b_resp_got), 64'd2);
    axi_rd(32'h40, 0, 3'd3, 2'b01, 8'h08, 0, 32'h0);
    chk("t5_rresp", 64'(rr[0]), 64'd2);
    chk("t5_rdata", 64'(rd[0]), 64'd0);
    axi_rd(32'h40, 0, 3'd2, 2'b01, 8'h09, 0, 32'h0);
    chk("t5_kept", 64'(rd[0]), 64'h12345678);

    // Early wlast: SLVERR, still two beats taken.
    wd[0] = 32'hAAAA0000; wd[1] = 32'hBBBB1111; wflip[0] = 1'b1;
    axi_wr(32'h50, 1, 3'd2, 2'b01, 8'h0A, 0);
    chk("t6_bresp", 64'(b_resp_got), 64'd2);
    axi_rd(32'h54, 0, 3'd2, 2'b01, 8'h0B, 0, 32'h0);
    chk("t6_beat1", 64'(rd[0]), 64'hBBBB1111);

    // FIXED burst: last beat wins at the same word.
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
    axi_wr(32'h60, 2, 3'd2, 2'b00, 8'h0C, 0);
    chk("t7_bresp", 64'(b_resp_got), 64'd0);
    axi_rd(32'h60, 0, 3'd2, 2'b01, 8'h0D, 0, 32'h0);
    chk("t7_rdata", 64'(rd[0]), 64'h3);

    // WRAP len=3 size=2 at 0x38 over known contents.
    wd[0] = 32'hC0; wd[1] = 32'hC1; wd[2] = 32'hC2; wd[3] = 32'hC3;
    axi_wr(32'h30, 3, 3'd2, 2'b01, 8'h0E, 0);
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    axi_wr(32'h38, 3, 3'd2, 2'b10, 8'h0F, 0);
`ifdef RENODE_AXI_SUBORDINATE_WRAP_EN
    chk("t4_bresp", 64'(b_resp_got), 64'd0);
    axi_rd(32'h30, 3, 3'd2, 2'b01, 8'h10, 0, 32'h0);
    chk("t4_w30", 64'(rd[0]), 64'hA2);
    chk("t4_w34", 64'(rd[1]), 64'hA3);
    chk("t4_w38", 64'(rd[2]), 64'hA0);
    chk("t4_w3c", 64'(rd[3]), 64'hA1);
    axi_rd(32'h38, 3, 3'd2, 2'b10, 8'h11, 0, 32'h0);
    chk("t4_rresp", 64'(rr[2]), 64'd0);
    chk("t4_rwrap", 64'(rd[2]), 64'hA2);
`else
    chk("t4_bresp", 64'(b_resp_got), 64'd2);
    axi_rd(32'h30, 3, 3'd2, 2'b01, 8'h10, 0, 32'h0);
    chk("t4_w30", 64'(rd[0]), 64'hC0);
    chk("t4_w3c", 64'(rd[3]), 64'hC3);
    axi_rd(32'h38, 3, 3'd2, 2'b10, 8'h11, 0, 32'h0);
    chk("t4_rresp", 64'(rr[2]), 64'd2);
    chk("t4_rdata", 64'(rd[2]), 64'd0);
`endif

    // Response stalls: payload held while ready is low.
    wd[0] = 32'h5EED5EED;
    axi_wr(32'h70, 0, 3'd2, 2'b01, 8'h21, 5);
    chk("t8_bresp", 64'(b_resp_got), 64'd0);
    axi_rd(32'h70, 0, 3'd2, 2'b01, 8'h22, 5, 32'h5EED5EED);
    chk("t8_rdata", 64'(rd[0]), 64'h5EED5EED);
    chk("t8_rlast", 64'(rl[0]), 64'd1);

    // Reset during beat 2 of an 8-beat read.
    araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arid = 8'h33; arvalid = 1'b1;
    wait_hi(3, "ar9");
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("t9_beat2_vld", 64'(rvalid), 64'd1);
    chk("t9_beat2_data", 64'(rdata), 64'hFFFF4444);
    areset = 1'b1;
    @(posedge clk); #1;
    chk("t9_rvalid_rst", 64'(rvalid), 64'd0);
    areset = 1'b0; rready = 1'b0;
    @(posedge clk); #1;
    chk("t9_arready", 64'(arready), 64'd1);
    chk("t9_awready", 64'(awready), 64'd1);
    chk("t9_no_resp", 64'({bvalid, rvalid}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/renode_axi_subordinate_ram.md
# renode_axi_subordinate_ram

AXI4 subordinate (responder) backed by an internal word-addressed RAM. It is the far end of a `renode_axi_if` connection: it accepts AW/W/AR requests from an AXI manager and returns B/R responses. Independent read and write engines allow one outstanding write burst and one outstanding read burst at a time. It is used as a target memory in co-simulation benches.

## Interface

- AddressWidth, 32, byte address width.
- DataWidth, 32, data bus width; must be 8, 16, 32 or 64. StrobeWidth = DataWidth/8.
- TransactionIdWidth, 8, ID width.
- MemoryDepth, 1024, number of DataWidth words; power of two.
- clk  input  1  clock; all logic on rising edge.
- areset  input  1  synchronous, active-high reset.
- awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awlock, awcache[3:0], awprot[2:0], awvalid  input  per AXI4  write address channel; lock/cache/prot ignored.
- awready  output  1  write address ready.
- wdata, wstrb, wlast, wvalid  input  DataWidth/StrobeWidth/1/1  write data channel.
- wready  output  1  write data ready.
- bid, bresp[1:0], bvalid  output  TransactionIdWidth/2/1  write response.
- bready  input  1.
- arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  input  per AXI4  read address channel.
- arready  output  1.
- rid, rdata, rresp[1:0], rlast, rvalid  output  TransactionIdWidth/DataWidth/2/1/1  read data channel.
- rready  input  1.

## Operation

- Response codes: OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11. EXOKAY never returned.
- Word index = addr >> log2(StrobeWidth). Index >= MemoryDepth: beat is DECERR; write discarded, read data 0.
- Burst checks at address handshake: awsize/arsize > log2(StrobeWidth) -> whole burst SLVERR, no memory writes, reads return 0. FIXED: address constant. INCR: address += 2**size per beat. WRAP: see Configuration. Reserved burst 2'b11 -> SLVERR.
- Write FSM: W_IDLE (awready=1) -> AW handshake -> W_DATA (wready=1); each W handshake writes bytes enabled by wstrb; beat counter reaches awlen -> W_RESP (bvalid=1, bid=captured awid) -> B handshake -> W_IDLE.
- Beat counter is authoritative: wlast on a non-final beat or missing on the final beat sets SLVERR for the burst; transfer length still awlen+1.
- bresp = most severe of all beats (DECERR > SLVERR > OKAY).
- Read FSM: R_IDLE (arready=1) -> AR handshake -> R_DATA (rvalid=1); rdata combinationally read from the RAM at current beat address; rresp per beat; rlast=1 on beat arlen; R handshake on last beat -> R_IDLE.
- Outputs stable while valid and not ready.
- Same-cycle write and read to same word: read returns pre-write contents.
- RAM contents not reset.

## Timing

- Reset: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0. First cycle after areset deasserts: awready=1, arready=1.
- AW handshake at edge N -> wready=1 in cycle N+1. Final W beat at edge M -> bvalid=1 in cycle M+1. B handshake at edge K -> awready=1 in cycle K+1.
- AR handshake at edge N -> rvalid=1 with beat 0 in cycle N+1; one beat per cycle while rready=1.
- Single-beat write minimum: 3 cycles AW to B accepted; read: 2 cycles AR to R accepted.
- areset mid-burst: burst aborted, no B/R response, FSMs to idle.

## Configuration

- RENODE_AXI_SUBORDINATE_WRAP_EN defined: WRAP bursts supported; legal only when len in {1,3,7,15} and address aligned to 2**size, otherwise SLVERR; wrap boundary = (len+1)*2**size, address wraps to aligned base.
- Not defined: any WRAP burst -> SLVERR for all beats, no writes, read data 0.

## Test plan

- Reset then single write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, then read 0x10 -> bresp=OKAY, rdata=0xDEADBEEF, rlast=1, IDs echoed.
- INCR write len=3 at 0x0, wstrb=4'b0011 on beat 2 over prior 0xFFFFFFFF -> readback beat 2 = 0xFFFFxxxx with lower half new data.
- Write awaddr=MemoryDepth*4 -> bresp=DECERR; read same -> rresp=DECERR, rdata=0.
- WRAP len=3 size=2 at 0x38: with macro, beats at 0x38,0x3C,0x30,0x34, OKAY; without, SLVERR.
- bready/rready held low 5 cycles -> bvalid/rvalid and payload held stable; areset during beat 2 of len=7 read -> rvalid=0 next cycle, arready=1 after reset.
